// File: rtl/ime_best_sel_if.sv
// Bus between the partition SAD combiner, the best-MV selector and mode decision.
// Candidate SAD/MV inputs on one side, the per-partition winners on the other.
interface ime_best_sel_if #(
  parameter int MV_W  = 7,
  parameter int CNT_W = 10
);
  logic                  start_i;
  logic                  sad_v_i;
  logic                  last_i;
  logic [MV_W-1:0]       mvx_i;
  logic [MV_W-1:0]       mvy_i;
  logic [4*14-1:0]       sad8x8_i;
  logic [2*15-1:0]       sad16x8_i;
  logic [2*15-1:0]       sad8x16_i;
  logic [15:0]           sad16x16_i;
  logic                  busy_o;
  logic                  done_o;
  logic [CNT_W-1:0]      cand_cnt_o;
  logic [4*14-1:0]       best_sad8x8_o;
  logic [2*15-1:0]       best_sad16x8_o;
  logic [2*15-1:0]       best_sad8x16_o;
  logic [15:0]           best_sad16x16_o;
  logic [4*2*MV_W-1:0]   best_mv8x8_o;
  logic [2*2*MV_W-1:0]   best_mv16x8_o;
  logic [2*2*MV_W-1:0]   best_mv8x16_o;
  logic [2*MV_W-1:0]     best_mv16x16_o;

  modport master (
    output start_i, sad_v_i, last_i, mvx_i, mvy_i,
           sad8x8_i, sad16x8_i, sad8x16_i, sad16x16_i,
    input  busy_o, done_o, cand_cnt_o,
           best_sad8x8_o, best_sad16x8_o, best_sad8x16_o, best_sad16x16_o,
           best_mv8x8_o, best_mv16x8_o, best_mv8x16_o, best_mv16x16_o
  );

  modport slave (
    input  start_i, sad_v_i, last_i, mvx_i, mvy_i,
           sad8x8_i, sad16x8_i, sad8x16_i, sad16x16_i,
    output busy_o, done_o, cand_cnt_o,
           best_sad8x8_o, best_sad16x8_o, best_sad8x16_o, best_sad16x16_o,
           best_mv8x8_o, best_mv16x8_o, best_mv8x16_o, best_mv16x16_o
  );
endinterface

// File: rtl/ime_best_sel.sv
// Integer-ME best-candidate selector: per-partition running minimum SAD and its MV
// over one macroblock search, presented with a done pulse after the last candidate.

module ime_best_part #(
  parameter int SAD_W = 14,
  parameter int MV_W  = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              init_i,
  input  logic              upd_i,
  input  logic [SAD_W-1:0]  sad_i,
  input  logic [2*MV_W-1:0] mv_i,
  output logic [SAD_W-1:0]  best_sad_o,
  output logic [2*MV_W-1:0] best_mv_o
);
  logic [SAD_W-1:0]  sad_q, sad_d;
  logic [2*MV_W-1:0] mv_q, mv_d;

  // Strict less-than: on a tie the earlier candidate stays.
  always_comb begin
    sad_d = sad_q;
    mv_d  = mv_q;
    if (init_i) begin
      sad_d = '1;
      mv_d  = '0;
    end else if (upd_i && (sad_i < sad_q)) begin
      sad_d = sad_i;
      mv_d  = mv_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sad_q <= '1;
      mv_q  <= '0;
    end else begin
      sad_q <= sad_d;
      mv_q  <= mv_d;
    end
  end

  assign best_sad_o = sad_q;
  assign best_mv_o  = mv_q;
endmodule

module ime_best_sel #(
  parameter int MV_W  = 7,
  parameter int CNT_W = 10
) (
  input logic           clk,
  input logic           rstn,
  ime_best_sel_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic [2*MV_W-1:0] mv_in;

  logic [3:0][13:0]       b_sad8x8;
  logic [1:0][14:0]       b_sad16x8, b_sad8x16;
  logic [15:0]            b_sad16x16;
  logic [3:0][2*MV_W-1:0] b_mv8x8;
  logic [1:0][2*MV_W-1:0] b_mv16x8, b_mv8x16;
  logic [2*MV_W-1:0]      b_mv16x16;

  assign mv_in = {bus.mvy_i, bus.mvx_i};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = (state_q == SEARCH) && bus.sad_v_i && !bus.start_i;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = SEARCH;
      SEARCH:  if (bus.start_i) state_d = SEARCH;
               else if (bus.sad_v_i && bus.last_i) state_d = DONE;
      DONE:    state_d = bus.start_i ? SEARCH : IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.start_i)               cnt_d = '0;
    else if (accept && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_8x8
    ime_best_part #(.SAD_W(14), .MV_W(MV_W)) u_part (
      .clk(clk), .rstn(rstn), .init_i(bus.start_i), .upd_i(accept),
      .sad_i(bus.sad8x8_i[g*14 +: 14]), .mv_i(mv_in),
      .best_sad_o(b_sad8x8[g]), .best_mv_o(b_mv8x8[g])
    );
  end

  for (genvar g = 0; g < 2; g++) begin : g_16
    ime_best_part #(.SAD_W(15), .MV_W(MV_W)) u_16x8 (
      .clk(clk), .rstn(rstn), .init_i(bus.start_i), .upd_i(accept),
      .sad_i(bus.sad16x8_i[g*15 +: 15]), .mv_i(mv_in),
      .best_sad_o(b_sad16x8[g]), .best_mv_o(b_mv16x8[g])
    );
    ime_best_part #(.SAD_W(15), .MV_W(MV_W)) u_8x16 (
      .clk(clk), .rstn(rstn), .init_i(bus.start_i), .upd_i(accept),
      .sad_i(bus.sad8x16_i[g*15 +: 15]), .mv_i(mv_in),
      .best_sad_o(b_sad8x16[g]), .best_mv_o(b_mv8x16[g])
    );
  end

  ime_best_part #(.SAD_W(16), .MV_W(MV_W)) u_16x16 (
    .clk(clk), .rstn(rstn), .init_i(bus.start_i), .upd_i(accept),
    .sad_i(bus.sad16x16_i), .mv_i(mv_in),
    .best_sad_o(b_sad16x16), .best_mv_o(b_mv16x16)
  );

  assign bus.busy_o          = (state_q == SEARCH);
  assign bus.done_o          = (state_q == DONE);
  assign bus.cand_cnt_o      = cnt_q;
  assign bus.best_sad8x8_o   = b_sad8x8;
  assign bus.best_sad16x8_o  = b_sad16x8;
  assign bus.best_sad8x16_o  = b_sad8x16;
  assign bus.best_sad16x16_o = b_sad16x16;
  assign bus.best_mv8x8_o    = b_mv8x8;
  assign bus.best_mv16x8_o   = b_mv16x8;
  assign bus.best_mv8x16_o   = b_mv8x16;
  assign bus.best_mv16x16_o  = b_mv16x16;
endmodule

// File: tb/tb_ime_best_sel.sv
// Directed bench for ime_best_sel: a candidate-list model recomputes every winner from
// scratch each cycle and is compared against the DUT, plus hand-computed spot checks.
module tb_ime_best_sel;
  localparam int MV_W = 7;
  localparam int CNT_W = 10;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ime_best_sel_if #(.MV_W(MV_W), .CNT_W(CNT_W)) bus ();
  ime_best_sel #(.MV_W(MV_W), .CNT_W(CNT_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct packed {
    logic [8:0][15:0] sad;  // 0-3 8x8, 4-5 16x8, 6-7 8x16, 8 16x16
    logic [13:0]      mv;   // {mvy,mvx}
  } cand_t;

  cand_t cands[$];
  int    phase = 0;  // 0 idle, 1 search, 2 done
  int    vecs = 0;
  int    errs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic cand_t cur();
    cand_t c;
    for (int g = 0; g < 4; g++) c.sad[g] = {2'b0, bus.sad8x8_i[g*14 +: 14]};
    for (int g = 0; g < 2; g++) begin
      c.sad[4+g] = {1'b0, bus.sad16x8_i[g*15 +: 15]};
      c.sad[6+g] = {1'b0, bus.sad8x16_i[g*15 +: 15]};
    end
    c.sad[8] = bus.sad16x16_i;
    c.mv = {bus.mvy_i, bus.mvx_i};
    return c;
  endfunction

  // Model: record accepted candidates of the current search.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase <= 0;
      cands.delete();
    end else if (bus.start_i) begin
      phase <= 1;
      cands.delete();
    end else if (phase == 1) begin
      if (bus.sad_v_i) begin
        cands.push_back(cur());
        if (bus.last_i) phase <= 2;
      end
    end else if (phase == 2) begin
      phase <= 0;
    end
  end

  // Winners recomputed from the whole candidate list every cycle.
  always @(negedge clk) begin
    logic [8:0][15:0] bs;
    logic [8:0][13:0] bm;
    logic [55:0] e8s, e8m;
    logic [29:0] e168s, e816s;
    logic [27:0] e168m, e816m;
    int w, n;
    for (int p = 0; p < 9; p++) begin
      w = (p < 4) ? 14 : (p < 8) ? 15 : 16;
      bs[p] = 16'((32'd1 << w) - 1);
      bm[p] = '0;
      foreach (cands[i]) if (cands[i].sad[p] < bs[p]) begin
        bs[p] = cands[i].sad[p];
        bm[p] = cands[i].mv;
      end
    end
    for (int g = 0; g < 4; g++) begin
      e8s[g*14 +: 14] = bs[g][13:0];
      e8m[g*14 +: 14] = bm[g];
    end
    for (int g = 0; g < 2; g++) begin
      e168s[g*15 +: 15] = bs[4+g][14:0];
      e816s[g*15 +: 15] = bs[6+g][14:0];
      e168m[g*14 +: 14] = bm[4+g];
      e816m[g*14 +: 14] = bm[6+g];
    end
    n = cands.size() > 1023 ? 1023 : cands.size();
    chk("busy", 64'(bus.busy_o), 64'(phase == 1));
    chk("done", 64'(bus.done_o), 64'(phase == 2));
    chk("cand_cnt", 64'(bus.cand_cnt_o), 64'(n));
    chk("sad8x8", 64'(bus.best_sad8x8_o), 64'(e8s));
    chk("sad16x8", 64'(bus.best_sad16x8_o), 64'(e168s));
    chk("sad8x16", 64'(bus.best_sad8x16_o), 64'(e816s));
    chk("sad16x16", 64'(bus.best_sad16x16_o), 64'(bs[8]));
    chk("mv8x8", 64'(bus.best_mv8x8_o), 64'(e8m));
    chk("mv16x8", 64'(bus.best_mv16x8_o), 64'(e168m));
    chk("mv8x16", 64'(bus.best_mv8x16_o), 64'(e816m));
    chk("mv16x16", 64'(bus.best_mv16x16_o), 64'(bm[8]));
  end

  function automatic logic [8:0][15:0] fill(input int v);
    logic [8:0][15:0] s;
    for (int p = 0; p < 9; p++) s[p] = 16'(v);
    return s;
  endfunction

  task automatic clr();
    bus.start_i = 0; bus.sad_v_i = 0; bus.last_i = 0;
    bus.mvx_i = '0; bus.mvy_i = '0;
    bus.sad8x8_i = '0; bus.sad16x8_i = '0; bus.sad8x16_i = '0; bus.sad16x16_i = '0;
  endtask

  task automatic send(input bit st, input bit v, input bit lst, input int mx, input int my,
                      input logic [8:0][15:0] s);
    bus.start_i = st; bus.sad_v_i = v; bus.last_i = lst;
    bus.mvx_i = mx[MV_W-1:0]; bus.mvy_i = my[MV_W-1:0];
    for (int g = 0; g < 4; g++) bus.sad8x8_i[g*14 +: 14] = s[g][13:0];
    for (int g = 0; g < 2; g++) begin
      bus.sad16x8_i[g*15 +: 15] = s[4+g][14:0];
      bus.sad8x16_i[g*15 +: 15] = s[6+g][14:0];
    end
    bus.sad16x16_i = s[8];
    @(posedge clk); #1;
    clr();
  endtask

  task automatic start();
    send(1, 0, 0, 0, 0, fill(0));
  endtask

  // Returns at the negedge of the first done cycle; done must appear right after last.
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (bus.done_o) begin
        seen = 1;
        chk("done_latency", 64'(i), 64'd0);
      end
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  logic [8:0][15:0] s;

  initial begin
    clr();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sad8x8", 64'(bus.best_sad8x8_o), 64'h00FF_FFFF_FFFF_FFFF);
    chk("rst_sad16x16", 64'(bus.best_sad16x16_o), 64'hFFFF);
    chk("rst_mv16x16", 64'(bus.best_mv16x16_o), 64'd0);
    rstn = 1;
    @(posedge clk); #1;

    // Basic min tracking on 16x16.
    start();
    send(0, 1, 0, 1, 1, fill(500));
    send(0, 1, 0, -2, 3, fill(300));
    send(0, 1, 1, 5, -5, fill(400));
    wait_done();
    chk("t1_sad16x16", 64'(bus.best_sad16x16_o), 64'd300);
    chk("t1_mv16x16", 64'(bus.best_mv16x16_o), 64'h01FE);
    chk("t1_cnt", 64'(bus.cand_cnt_o), 64'd3);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    // Independent partitions.
    start();
    s = fill(200); s[0] = 10; s[6] = 50;
    send(0, 1, 0, -1, 0, s);
    s = fill(200); s[3] = 10; s[7] = 40;
    send(0, 1, 0, 4, 4, s);
    s = fill(200); s[4] = 10; s[8] = 150;
    send(0, 1, 1, 2, -3, s);
    wait_done();
    chk("t2_mv_blk0", 64'(bus.best_mv8x8_o[13:0]), 64'h007F);
    chk("t2_mv_blk3", 64'(bus.best_mv8x8_o[55:42]), 64'h0204);
    chk("t2_mv_top", 64'(bus.best_mv16x8_o[13:0]), 64'h3E82);
    @(posedge clk); #1;

    // Tie keeps the earlier MV.
    start();
    send(0, 1, 0, 0, 0, fill(100));
    send(0, 1, 1, 3, 3, fill(100));
    wait_done();
    chk("t3_tie_mv", 64'(bus.best_mv16x16_o), 64'd0);
    @(posedge clk); #1;

    // Abort mid-search.
    start();
    send(0, 1, 0, 1, 2, fill(100));
    send(0, 1, 0, 3, 4, fill(50));
    start();
    send(0, 1, 1, 7, 7, fill(900));
    wait_done();
    chk("t4_sad", 64'(bus.best_sad16x16_o), 64'd900);
    chk("t4_cnt", 64'(bus.cand_cnt_o), 64'd1);

    // Start in the DONE cycle, with a coincident candidate that must be dropped.
    send(1, 1, 0, 9, 9, fill(1));
    send(0, 1, 0, -4, -4, fill(60));
    send(0, 1, 1, 6, 6, fill(70));
    wait_done();
    chk("t5_sad", 64'(bus.best_sad16x16_o), 64'd60);
    chk("t5_cnt", 64'(bus.cand_cnt_o), 64'd2);
    @(posedge clk); #1;

    // Reset mid-search.
    start();
    send(0, 1, 0, 5, 5, fill(20));
    rstn = 0;
    @(negedge clk);
    chk("t6_busy", 64'(bus.busy_o), 64'd0);
    chk("t6_sad", 64'(bus.best_sad16x16_o), 64'hFFFF);
    chk("t6_cnt", 64'(bus.cand_cnt_o), 64'd0);
    @(posedge clk); #1;
    rstn = 1;
    @(posedge clk); #1;

    // Counter saturation; comparison keeps going past it.
    start();
    for (int i = 0; i < 1030; i++)
      send(0, 1, i == 1029, i % 50, 0, fill(i == 1027 ? 5 : 500 - (i % 7)));
    wait_done();
    chk("t7_cnt_sat", 64'(bus.cand_cnt_o), 64'd1023);
    chk("t7_sad", 64'(bus.best_sad16x16_o), 64'd5);
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ime_best_sel.md
Name: ime_best_sel

Overview:
- Integer-ME decision stage directly downstream of the partition SAD combiner (8x8 → 8x16/16x8/16x16).
- For one macroblock search, consumes one set of 9 partition SADs per candidate MV, tracks the minimum SAD and its MV per partition, and presents the 9 winners to the mode-decision/FME stage when the search completes.

Parameters:
- MV_W, 7, signed width of each MV component in integer pels (range -64..63).
- CNT_W, 10, width of the candidate counter.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse: begin a new MB search
- sad_v_i  in  1  candidate SAD set valid this cycle
- last_i  in  1  qualifies sad_v_i: final candidate of this MB
- mvx_i  in  MV_W  candidate MV x (signed), aligned with sad_v_i
- mvy_i  in  MV_W  candidate MV y (signed), aligned with sad_v_i
- sad8x8_i  in  4*14  8x8 SADs: [13:0]=blk0 (TL), blk1 TR, blk2 BL, blk3 BR
- sad16x8_i  in  2*15  [14:0]=top, [29:15]=bottom
- sad8x16_i  in  2*15  [14:0]=left, [29:15]=right
- sad16x16_i  in  16  16x16 SAD
- busy_o  out  1  high while in SEARCH
- done_o  out  1  one-cycle pulse: results valid
- cand_cnt_o  out  CNT_W  candidates evaluated this MB
- best_sad8x8_o  out  4*14  minimum SADs, same packing as input
- best_sad16x8_o  out  2*15  same packing as input
- best_sad8x16_o  out  2*15  same packing as input
- best_sad16x16_o  out  16  same packing as input
- best_mv8x8_o  out  4*2*MV_W  per partition {mvy,mvx}, x in low bits
- best_mv16x8_o  out  2*2*MV_W  per partition {mvy,mvx}, x in low bits
- best_mv8x16_o  out  2*2*MV_W  per partition {mvy,mvx}, x in low bits
- best_mv16x16_o  out  2*MV_W  {mvy,mvx}, x in low bits

Behaviour:
- Reset (async, rstn low):
  - State IDLE.
  - busy_o=0, done_o=0, cand_cnt_o=0.
  - All best SAD fields all-ones; all MV fields 0.
- FSM states: IDLE, SEARCH, DONE.
  - IDLE --start_i--> SEARCH.
  - SEARCH --(sad_v_i & last_i)--> DONE.
  - SEARCH --start_i--> SEARCH (restart).
  - DONE --> IDLE unconditionally after 1 cycle.
  - DONE --start_i--> SEARCH (start has priority).
- On start_i, at the next edge:
  - Every best SAD is set to all-ones of its width.
  - Every MV is set to 0.
  - cand_cnt_o is cleared.
- start_i has priority over sad_v_i: a candidate in the same cycle as start_i is discarded.
- start_i during SEARCH aborts the current search: re-initialise, no done_o.
- In SEARCH, each cycle with sad_v_i=1, the 9 partitions are compared independently:
  - Update the partition if input SAD < stored SAD (strict, unsigned); store SAD and {mvy_i,mvx_i}.
  - Ties keep the earlier candidate.
- Updates are registered at the edge after sad_v_i; throughput is one candidate per cycle, with no back-pressure.
- cand_cnt_o increments per accepted candidate and saturates at 2^CNT_W-1; comparison continues after saturation.
- The last candidate (sad_v_i & last_i) is compared and registered at the same edge that enters DONE.
  - done_o=1 during the DONE cycle, with final results already on the outputs.
  - Result latency is 1 cycle after the last candidate.
- Results hold stable after DONE until the next start_i takes effect.
- sad_v_i outside SEARCH is ignored.
- last_i without sad_v_i is ignored.
- busy_o=1 exactly in SEARCH.
- A search with zero candidates never completes; it is aborted by the next start_i.
- No arithmetic is performed and there is no MV cost: MVs are stored verbatim (two's complement).

Test Plan:
- Reset → all best SADs all-ones (8x8 0x3FFF, 16x16 0xFFFF), MVs 0, done_o=0, busy_o=0.
- start, 3 candidates with 16x16 SAD 500@(1,1), 300@(-2,3), 400@(5,-5, last) → done_o 1 cycle after last; best16x16=300, mv=(-2,3); cand_cnt=3.
- Per-partition independence: blk0 min at cand A (-1,0), blk3 min at cand B (4,4), 16x8 top min at cand C → each partition reports its own MV; 8x16/16x8 winners can differ from the 8x8 winners.
- Tie: two candidates with equal SAD 100 at (0,0) then (3,3) → MV (0,0) retained.
- start_i mid-search after 2 candidates, then 1 candidate SAD 900 with last → no done_o on abort; final best=900 (old values discarded); cand_cnt=1.
- Back-to-back MBs: start_i in the DONE cycle → done_o pulses once; new search re-initialises; sad_v_i coincident with start_i is discarded; rstn asserted mid-search → immediate return to reset values.
